// File: rtl/seven_seg_scan.sv
// Four-digit multiplexed common-anode 7-segment driver with per-frame digit snapshot.
// Optional leading-zero blanking is enabled by defining SEVEN_SEG_LEADING_ZERO_BLANK_EN.
module seven_seg_scan #(
   parameter int REFRESH_DIV = 50000
) (
   input  logic        clk,
   input  logic        rst,
   input  logic [31:0] units,
   input  logic [31:0] tens,
   input  logic [31:0] hundreds,
   input  logic [31:0] thousands,
   input  logic        en,
   input  logic [3:0]  dp_sel,
   output logic [3:0]  an,
   output logic [6:0]  seg,
   output logic        dp_n,
   output logic        frame_done
);

   localparam int CW = $clog2(REFRESH_DIV);
   localparam logic [CW-1:0] LAST = CW'(REFRESH_DIV - 1);

   logic [CW-1:0] cnt;
   logic [1:0]    idx;
   // Units are taken straight from the input on the wrap edge, so only the
   // three upper digits need holding for the rest of the frame.
   logic [31:0]   snap1, snap2, snap3;

   logic          tick;
   logic [1:0]    nidx;
   logic [31:0]   cur;
   logic          blank;
   logic [3:0]    an_nxt;
   logic [6:0]    seg_nxt;
   logic          dp_nxt;

   function automatic logic [6:0] decode(input logic [31:0] v);
      case (v)
         32'd0:   decode = 7'b1000000;
         32'd1:   decode = 7'b1111001;
         32'd2:   decode = 7'b0100100;
         32'd3:   decode = 7'b0110000;
         32'd4:   decode = 7'b0011001;
         32'd5:   decode = 7'b0010010;
         32'd6:   decode = 7'b0000010;
         32'd7:   decode = 7'b1111000;
         32'd8:   decode = 7'b0000000;
         32'd9:   decode = 7'b0010000;
         default: decode = 7'b0111111;
      endcase
   endfunction

   always_comb begin
      tick = (cnt == LAST);
      nidx = idx + 2'd1;
      cur  = units;
      case (nidx)
         2'd1:    cur = snap1;
         2'd2:    cur = snap2;
         2'd3:    cur = snap3;
         default: cur = units;
      endcase
      blank = 1'b0;
`ifdef SEVEN_SEG_LEADING_ZERO_BLANK_EN
      case (nidx)
         2'd1:    blank = (snap1 == 32'd0) && (snap2 == 32'd0) && (snap3 == 32'd0);
         2'd2:    blank = (snap2 == 32'd0) && (snap3 == 32'd0);
         2'd3:    blank = (snap3 == 32'd0);
         default: blank = 1'b0;
      endcase
`endif
      an_nxt  = (en && !blank) ? ~(4'b0001 << nidx) : 4'b1111;
      seg_nxt = blank ? 7'b1111111 : decode(cur);
      dp_nxt  = blank ? 1'b1 : ~(dp_sel[nidx] & en);
   end

   always_ff @(posedge clk) begin
      if (rst) begin
         cnt        <= LAST;
         idx        <= 2'd3;
         snap1      <= '0;
         snap2      <= '0;
         snap3      <= '0;
         an         <= 4'b1111;
         seg        <= 7'b1111111;
         dp_n       <= 1'b1;
         frame_done <= 1'b0;
      end else begin
         frame_done <= 1'b0;
         if (tick) begin
            cnt  <= '0;
            idx  <= nidx;
            an   <= an_nxt;
            seg  <= seg_nxt;
            dp_n <= dp_nxt;
            if (idx == 2'd3) begin
               snap1      <= tens;
               snap2      <= hundreds;
               snap3      <= thousands;
               frame_done <= 1'b1;
            end
         end else begin
            cnt <= cnt + CW'(1);
         end
      end
   end

endmodule

// File: tb/tb_seven_seg_scan.sv
// Scoreboard bench for seven_seg_scan: expected per-slot outputs are queued per frame
// and compared on every cycle of each digit slot. Honors SEVEN_SEG_LEADING_ZERO_BLANK_EN.
module tb_seven_seg_scan;

   localparam int RD = 4;

   logic        clk = 1'b0;
   logic        rst;
   logic [31:0] units, tens, hundreds, thousands;
   logic        en;
   logic [3:0]  dp_sel;
   logic [3:0]  an;
   logic [6:0]  seg;
   logic        dp_n;
   logic        frame_done;

   int checks   = 0;
   int failures = 0;

   // {frame_done_on_first_cycle, an[3:0], seg[6:0], dp_n}
   logic [12:0] exp_q[$];
   logic [31:0] pend_units;

   seven_seg_scan #(.REFRESH_DIV(RD)) dut (
      .clk        (clk),
      .rst        (rst),
      .units      (units),
      .tens       (tens),
      .hundreds   (hundreds),
      .thousands  (thousands),
      .en         (en),
      .dp_sel     (dp_sel),
      .an         (an),
      .seg        (seg),
      .dp_n       (dp_n),
      .frame_done (frame_done)
   );

   always #5 clk = ~clk;

   task automatic check_eq(input string tag, input logic [31:0] got, input logic [31:0] exp);
      checks++;
      if (got !== exp) begin
         failures++;
         $display("FAIL %s got=%h exp=%h t=%0t", tag, got, exp, $time);
      end
   endtask

   function automatic logic [6:0] ref_seg(input logic [31:0] v);
      logic [6:0] tab [10];
      tab = '{7'b1000000, 7'b1111001, 7'b0100100, 7'b0110000, 7'b0011001,
              7'b0010010, 7'b0000010, 7'b1111000, 7'b0000000, 7'b0010000};
      return (v < 32'd10) ? tab[v] : 7'b0111111;
   endfunction

   task automatic push_slot(input int k, input logic [31:0] d0, d1, d2, d3,
                            input logic e, input logic [3:0] dps);
      logic [31:0] d [4];
      logic        blk;
      logic [3:0]  one_hot;
      logic [3:0]  a;
      logic [6:0]  s;
      logic        p;
      d = '{d0, d1, d2, d3};
      blk = 1'b0;
`ifdef SEVEN_SEG_LEADING_ZERO_BLANK_EN
      blk = (k != 0);
      for (int j = k; j < 4; j++)
         if (d[j] != 32'd0) blk = 1'b0;
`endif
      one_hot = 4'b0001 << k;
      a = (e && !blk) ? ~one_hot : 4'b1111;
      s = blk ? 7'b1111111 : ref_seg(d[k]);
      p = blk ? 1'b1 : ~(dps[k] & e);
      exp_q.push_back({(k == 0), a, s, p});
   endtask

   task automatic push_frame(input logic [31:0] d0, d1, d2, d3,
                             input logic e, input logic [3:0] dps);
      for (int k = 0; k < 4; k++) push_slot(k, d0, d1, d2, d3, e, dps);
   endtask

   // Checks every cycle of one digit slot; optionally swaps in pend_units mid-slot.
   task automatic check_slot(input int chg_at);
      logic [12:0] e;
      check_eq("sb_nonempty", 32'(exp_q.size() > 0), 32'd1);
      if (exp_q.size() == 0) return;
      e = exp_q.pop_front();
      for (int i = 0; i < RD; i++) begin
         @(posedge clk);
         @(negedge clk);
         check_eq("an", 32'(an), 32'(e[11:8]));
         check_eq("seg", 32'(seg), 32'(e[7:1]));
         check_eq("dp_n", 32'(dp_n), 32'(e[0]));
         check_eq("frame_done", 32'(frame_done), (i == 0) ? 32'(e[12]) : 32'd0);
         if (i == chg_at) units = pend_units;
      end
   endtask

   task automatic check_reset_outputs();
      check_eq("rst_an", 32'(an), 32'h0000000f);
      check_eq("rst_seg", 32'(seg), 32'h0000007f);
      check_eq("rst_dp_n", 32'(dp_n), 32'd1);
      check_eq("rst_frame_done", 32'(frame_done), 32'd0);
   endtask

   initial begin
      logic [12:0] e;
      rst = 1'b1; en = 1'b1; dp_sel = 4'b0000;
      units = 32'd4; tens = 32'd3; hundreds = 32'd2; thousands = 32'd1;
      pend_units = 32'd0;
      repeat (3) @(posedge clk);
      @(negedge clk);
      check_reset_outputs();
      rst = 1'b0;

      // Basic scan, two frames of 1,2,3,4
      push_frame(4, 3, 2, 1, 1'b1, 4'b0000);
      push_frame(4, 3, 2, 1, 1'b1, 4'b0000);
      repeat (8) check_slot(-1);

      // Units change two cycles into the tens slot stays out of this frame
      push_frame(4, 3, 2, 1, 1'b1, 4'b0000);
      pend_units = 32'd9;
      check_slot(-1);
      check_slot(1);
      check_slot(-1);
      check_slot(-1);
      push_frame(9, 3, 2, 1, 1'b1, 4'b0000);
      repeat (4) check_slot(-1);

      // Out-of-range thousands shows a dash, zeros shown normally
      units = 32'd0; tens = 32'd0; hundreds = 32'd0; thousands = 32'd12;
      push_frame(0, 0, 0, 12, 1'b1, 4'b0000);
      repeat (4) check_slot(-1);

      // Reset while idx==2, then restart with fresh inputs
      units = 32'd4; tens = 32'd3; hundreds = 32'd2; thousands = 32'd1;
      push_slot(0, 4, 3, 2, 1, 1'b1, 4'b0000);
      push_slot(1, 4, 3, 2, 1, 1'b1, 4'b0000);
      push_slot(2, 4, 3, 2, 1, 1'b1, 4'b0000);
      check_slot(-1);
      check_slot(-1);
      e = exp_q.pop_front();
      @(posedge clk);
      @(negedge clk);
      check_eq("hund_an", 32'(an), 32'(e[11:8]));
      check_eq("hund_seg", 32'(seg), 32'(e[7:1]));
      rst = 1'b1;
      units = 32'd5;
      @(posedge clk);
      @(negedge clk);
      check_reset_outputs();
      rst = 1'b0;
      push_frame(5, 3, 2, 1, 1'b1, 4'b0000);
      repeat (4) check_slot(-1);

      // Display disabled for a full frame, then re-enabled with tens point
      en = 1'b0; dp_sel = 4'b0010;
      push_frame(5, 3, 2, 1, 1'b0, 4'b0010);
      repeat (4) check_slot(-1);
      en = 1'b1;
      push_frame(5, 3, 2, 1, 1'b1, 4'b0010);
      repeat (4) check_slot(-1);

      // Leading zeros: blanked only when the optional feature is built in
      dp_sel = 4'b0000;
      units = 32'd7; tens = 32'd0; hundreds = 32'd0; thousands = 32'd0;
      push_frame(7, 0, 0, 0, 1'b1, 4'b0000);
      repeat (4) check_slot(-1);

      // A random-valued frame as a last sweep across the decode table
      units = $urandom_range(0, 15); tens = $urandom_range(0, 15);
      hundreds = $urandom_range(0, 15); thousands = $urandom_range(0, 15);
      push_frame(units, tens, hundreds, thousands, 1'b1, 4'b0000);
      repeat (4) check_slot(-1);

      $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
      $finish;
   end

endmodule

// File: doc/seven_seg_scan.md
Name: seven_seg_scan

Overview:
- Time-multiplexed 4-digit 7-segment driver, directly downstream of the BCD converter.
- Consumes the BCD converter's units/tens/hundreds/thousands outputs and drives a common-anode display (active-low anodes and segments).
- Snapshots all four digits once per scan frame so a value never shows torn across digits.
- Output stage of the UART receive side of the board.

Parameters:
- REFRESH_DIV, 50000: clock cycles each digit stays lit (>=2); frame = 4*REFRESH_DIV cycles.

Ports:
- clk  in  1  system clock; all state updates on the rising edge.
- rst  in  1  synchronous, active-high reset.
- units  in  32  digit 0 value from the BCD stage.
- tens  in  32  digit 1 value.
- hundreds  in  32  digit 2 value.
- thousands  in  32  digit 3 value.
- en  in  1  display enable; 0 forces all anodes off.
- dp_sel  in  4  per-digit decimal point request; bit i lights the point on digit i.
- an  out  4  active-low anode select; bit i = digit i (bit 0 = units).
- seg  out  7  active-low segments {g,f,e,d,c,b,a}.
- dp_n  out  1  active-low decimal point.
- frame_done  out  1  one-cycle pulse on each snapshot edge.

Behaviour:
- State:
  - Prescaler cnt counts 0..REFRESH_DIV-1.
  - Digit index idx is 2 bits.
  - Snapshot registers snap0..snap3 are 32 bits each.
- Tick: the edge on which cnt==REFRESH_DIV-1. On a tick, cnt<=0 and idx<=idx+1 (mod 4); otherwise cnt<=cnt+1.
- Reset (rst=1 at an edge):
  - cnt<=REFRESH_DIV-1, idx<=3, snap*<=0.
  - an<=4'b1111, seg<=7'b1111111, dp_n<=1, frame_done<=0.
  - The first edge after rst falls is therefore a tick into idx 0.
- Snapshot: on a tick where idx==3 (wrap to 0), snap0..3 <= units..thousands and frame_done<=1. frame_done is 0 on every other edge. It also pulses on the first edge after reset.
- Outputs are registered and change only on tick edges (or on reset). On a tick into index k:
  - an <= ~(1<<k) when en=1, else 4'b1111.
  - seg <= decode(digit k). For k=0 the digit comes from the inputs being snapshotted on that same edge; for k=1..3 it comes from snapk.
  - dp_n <= ~(dp_sel[k] & en).
- Latency: an input change is displayed starting at the next wrap tick, at most 4*REFRESH_DIV cycles later. Mid-frame input changes never alter the remaining digits of the current frame.
- Decode (full 32-bit value, active low):
  - 0=1000000, 1=1111001, 2=0100100, 3=0110000, 4=0011001
  - 5=0010010, 6=0000010, 7=1111000, 8=0000000, 9=0010000
  - any value >9 → dash 0111111.
- en:
  - en only affects an and dp_n, sampled at each tick. Scanning and snapshots continue while en=0.
  - en deasserted mid-digit takes effect at the next tick.
- Reset mid-frame: takes priority over a tick on the same edge. The display restarts at units on the first edge after release, with fresh inputs.

Optional Feature:
- Macro: SEVEN_SEG_LEADING_ZERO_BLANK_EN.
- Defined:
  - A digit k in 1..3 is blanked when its value is 0 and every higher digit in the same frame is 0. Higher digits mean the snapshot for k>=1; for the digit-0 decision, use the inputs being loaded.
  - A blanked digit drives an=4'b1111, seg=7'b1111111, dp_n=1 for its slot; scan timing is unchanged.
  - Units are never blanked.
- Undefined: all four digits are always shown, including leading zeros.

Test Plan:
- REFRESH_DIV=4, en=1, dp_sel=0, digits 1,2,3,4 (thousands..units), release rst →
  - frame_done pulses on the first edge.
  - an=1110/seg=0011001 for 4 cycles, then an=1101/0110000, then 1011/0100100, then 0111/1111001.
  - The sequence repeats every 16 cycles.
- Same setup, change units to 9 two cycles into the tens slot → current frame unchanged; the next frame shows seg=0010000 on an=1110.
- thousands=12, others 0 → an=0111 slot shows seg=0111111 (dash); the other slots show 1000000.
- Assert rst for 1 cycle while idx=2 → next edge an=1111, seg=1111111. The edge after release shows units on an=1110 and frame_done=1.
- en=0 for one full frame with dp_sel=4'b0010 → an=1111 and dp_n=1 throughout. After en=1, the tens slot shows dp_n=0.
- With SEVEN_SEG_LEADING_ZERO_BLANK_EN and digits 0,0,0,7 → only the an=1110 slot lights (seg=1111000); the other slots give an=1111. Without the macro, all slots light and show 1000000 for the zeros.
